// File: rtl/ripple_pkg.sv
// Shared types and helpers for capturing an asynchronous ripple counter.
package ripple_pkg;

    localparam int CNT_W_DEFAULT = 4;

    typedef enum logic {
        FILL   = 1'b0,
        STABLE = 1'b1
    } filt_state_t;

    // Modular difference a-b truncated to w bits (w up to 16).
    function automatic logic [15:0] mod_delta(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input int          w);
        logic [15:0] diff;
        logic [15:0] mask;
        diff = a - b;
        mask = (16'd1 << w) - 16'd1;
        return diff & mask;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic-width two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ripple_count_capture.sv
// Brings a ripple counter into the clk domain, filters transients, accumulates
// modular deltas into a wide total and offers snapshots over valid/ready.
module ripple_count_capture
    import ripple_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter int TOTAL_W       = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [CNT_W-1:0]   ripple_q,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic               out_wrap,
    output logic               overrun
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0]   w_sync_q;
    logic [CNT_W-1:0]   r_prev_q;
    filt_state_t        r_state;
    filt_state_t        w_state_nxt;
    logic [3:0]         r_stab_cnt;
    logic [3:0]         w_stab_nxt;
    logic               w_equal;
    logic               w_accept;

    logic [CNT_W-1:0]   r_base;
    logic [TOTAL_W-1:0] r_total;
    logic               r_wrap_pend;
    logic               r_out_valid;
    logic [TOTAL_W-1:0] r_out_total;
    logic               r_out_wrap;
    logic               r_overrun;

    logic [15:0]        w_delta;
    logic [TOTAL_W:0]   w_sum;
    logic               w_carry;
    logic               w_upd;
    logic               w_load;
    logic               w_xfer;

    sync_2ff #(.WIDTH(CNT_W)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (ripple_q),
        .o_q     (w_sync_q)
    );

    assign w_equal = (w_sync_q == r_prev_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= FILL;
            r_stab_cnt <= 4'd0;
            r_prev_q   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stab_cnt <= w_stab_nxt;
            r_prev_q   <= w_sync_q;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_equal && (r_stab_cnt == STAB_LAST)) w_state_nxt = STABLE;
            STABLE:  if (!w_equal) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // The accept fires once per settled value; STABLE only watches for the next change.
    always_comb begin
        w_accept   = 1'b0;
        w_stab_nxt = 4'd0;
        case (r_state)
            FILL: begin
                if (!w_equal) begin
                    w_stab_nxt = 4'd0;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_accept   = 1'b1;
                    w_stab_nxt = 4'd0;
                end else begin
                    w_stab_nxt = r_stab_cnt + 4'd1;
                end
            end
            default: w_stab_nxt = 4'd0;
        endcase
    end

    assign w_delta = mod_delta(16'(w_sync_q), 16'(r_base), CNT_W);
    assign w_sum   = {1'b0, r_total} + (TOTAL_W + 1)'(w_delta);
    assign w_carry = w_sum[TOTAL_W];
    assign w_upd   = w_accept && (w_delta != 16'd0);
    assign w_xfer  = r_out_valid && out_ready;
    assign w_load  = w_upd && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base      <= '0;
            r_total     <= '0;
            r_wrap_pend <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_wrap  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_total     <= '0;
            r_wrap_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_valid <= 1'b0;
            r_base      <= w_sync_q;
        end else begin
            if (w_accept) r_base <= w_sync_q;
            if (w_upd) r_total <= w_sum[TOTAL_W-1:0];
            if (w_load) begin
                r_out_total <= w_sum[TOTAL_W-1:0];
                r_out_wrap  <= r_wrap_pend | w_carry;
                r_out_valid <= 1'b1;
                r_wrap_pend <= 1'b0;
            end else begin
                // Downstream still holds the old snapshot: keep counting, remember the carry.
                if (w_upd) begin
                    r_overrun   <= 1'b1;
                    r_wrap_pend <= r_wrap_pend | w_carry;
                end
                if (w_xfer) r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_total = r_out_total;
    assign out_wrap  = r_out_wrap;
    assign overrun   = r_overrun;

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Consumes the 4-bit output of the asynchronous ripple up-counter and brings it safely into the system `clk` domain.
- Synchronises each bit, then accepts a value only after it has been stable for a programmable window. This rejects ripple transients such as 0111→0110→0100→0000→1000.
- Accepts all deltas modulo 2^CNT_W and accumulates them into a wide total.
- Presents snapshots of the total over a valid/ready handshake to the downstream event logger.

Parameters:
- CNT_W, 4, width of the ripple counter value.
- TOTAL_W, 16, width of the accumulated event total.
- STABLE_CYCLES, 2, consecutive equal synchronised samples required before accepting (range 1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ripple_q  in  CNT_W  asynchronous counter value from the ripple counter.
- clear  in  1  synchronous clear of total, baseline and flags.
- out_valid  out  1  snapshot available.
- out_ready  in  1  downstream accepts the snapshot.
- out_total  out  TOTAL_W  snapshot of the accumulated total.
- out_wrap  out  1  snapshot flag: total wrapped past 2^TOTAL_W-1 since the previous snapshot.
- overrun  out  1  sticky: an accept occurred while out_valid && !out_ready.

Behaviour:
- Reset state (async, reset_n low):
  - Synchroniser flops, stable counter, baseline and total are all 0.
  - out_valid=0, out_total=0, out_wrap=0, overrun=0.
  - Internal wrap_pend=0.
  - Filter state is FILL.
- Synchroniser:
  - Two flops per bit, no logic between them. This gives sync_q.
  - Gray coding is not available, so the filter below provides integrity.
- Filter FSM (states FILL, STABLE):
  - FILL:
    - Compare sync_q with its value one cycle earlier (prev_q).
    - Equal → stab_cnt++. Different → stab_cnt=0.
    - When stab_cnt reaches STABLE_CYCLES-1 with equality, go to STABLE and emit a one-cycle accept, with cand=sync_q.
  - STABLE:
    - Stay while sync_q==prev_q.
    - On any change → FILL, stab_cnt=0.
- Accept processing (same cycle as accept):
  - delta = (cand - baseline) mod 2^CNT_W, then baseline←cand.
  - delta==0 causes no update and no snapshot.
  - Otherwise total←total+delta (TOTAL_W wraparound). If the add carries out, wrap_pend←1.
  - Snapshot load if !out_valid || out_ready:
    - out_total←new total, out_wrap←wrap_pend|carry, out_valid←1, wrap_pend←0.
  - Otherwise out_total/out_wrap are held, overrun←1 (sticky), and the total keeps accumulating.
- Latency: ripple_q change → out_valid = 2 sync cycles + STABLE_CYCLES cycles + 1 register cycle. For STABLE_CYCLES=2 this is 5 clk.
- Handshake:
  - out_valid stays high and out_total/out_wrap stay stable until a cycle with out_valid && out_ready.
  - After that transfer, out_valid drops next cycle unless a simultaneous accept reloads it.
  - Accept and transfer in the same cycle → load the new snapshot and keep out_valid=1.
- Counter wrap (ripple 15→0):
  - Modular delta gives 1; there is no special case.
  - Deltas ≥ 2^CNT_W between accepts are unrecoverable. The system constraint is that the ripple clock is slower than clk/(STABLE_CYCLES+3).
- clear:
  - Sets total=0, wrap_pend=0, overrun=0, out_valid=0.
  - Sets baseline←sync_q so there is no spurious delta.
  - Filter state is unaffected.
  - clear has priority over an accept in the same cycle.
- Reset mid-transaction: out_valid drops immediately (async). After release, the first accept uses baseline 0.

Decomposition:
- Shared package ripple_pkg holds:
  - CNT_W default constant.
  - Enum filt_state_t {FILL, STABLE}.
  - Function mod_delta(a,b).
- One sub-module, sync_2ff (generic-width two-flop synchroniser, clk/reset_n). It is reused for other async inputs.
- The filter, accumulator and handshake stay in the top module.

Test Plan:
- Reset, then hold ripple_q=0 → out_valid stays 0, out_total=0, overrun=0 for 50 cycles.
- Drive ripple_q 0→3 cleanly, out_ready=1 → out_valid pulses exactly 5 clk later with out_total=3.
- Glitch sequence 7→6→4→0→8, each code held 1 clk, then 8 held steady → exactly one snapshot with out_total=8 and no intermediate snapshots.
- Step ripple_q 14→15→0→1 (each held 20 clk) from baseline 14 → out_total increments by 1 each time: 15,16,17. Wrap counts correctly.
- out_ready=0, apply two changes (0→2, 2→5) → first snapshot out_total=2 held, overrun=1. After out_ready=1, the next snapshot requires a further change; make it 5→6 → out_total=6.
- Preload total to 0xFFFE via repeated steps, then step by 3 → out_total=0x0001, out_wrap=1. Assert clear with ripple_q=9 → out_valid=0, total 0, and the next step to 10 gives out_total=1.
